// File: rtl/cpu_rp2a03_apu_length_counter_bank_pkg.sv
// Shared constants and the note-length lookup table for the APU length counter bank.
package cpu_rp2a03_apu_pkg;

   localparam int unsigned LEN_IDX_W  = 5;
   localparam int unsigned APU_MAX_CH = 8;

   // Odd indices encode short linear lengths; even indices encode tempo-based note lengths.
   function automatic logic [7:0] length_lut(input logic [LEN_IDX_W-1:0] idx);
      logic [7:0] w_val;
      if (idx[0]) begin
         w_val = (idx == 5'd1) ? 8'd254 : ({3'b000, idx} - 8'd1);
      end else begin
         case (idx[4:1])
            4'd0:    w_val = 8'd10;
            4'd1:    w_val = 8'd20;
            4'd2:    w_val = 8'd40;
            4'd3:    w_val = 8'd80;
            4'd4:    w_val = 8'd160;
            4'd5:    w_val = 8'd60;
            4'd6:    w_val = 8'd14;
            4'd7:    w_val = 8'd26;
            4'd8:    w_val = 8'd12;
            4'd9:    w_val = 8'd24;
            4'd10:   w_val = 8'd48;
            4'd11:   w_val = 8'd96;
            4'd12:   w_val = 8'd192;
            4'd13:   w_val = 8'd72;
            4'd14:   w_val = 8'd16;
            default: w_val = 8'd32;
         endcase
      end
      return w_val;
   endfunction

endpackage

// File: rtl/cpu_rp2a03_apu_length_counter_bank_if.sv
// Register-write and status bus between the APU register file and the length counter bank.
interface cpu_rp2a03_apu_length_counter_bank_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned LEN_W  = 8
);

   logic [NUM_CH-1:0]       load_wr_i;
   logic [5*NUM_CH-1:0]     load_data_i;
   logic [NUM_CH-1:0]       halt_wr_i;
   logic [NUM_CH-1:0]       halt_data_i;
   logic                    status_wr_i;
   logic [NUM_CH-1:0]       status_wr_data_i;
   logic                    half_frame_i;
   logic [NUM_CH-1:0]       enabled_o;
   logic [NUM_CH-1:0]       length_nzero_o;
   logic [LEN_W*NUM_CH-1:0] length_o;

   modport master (
      output load_wr_i, load_data_i, halt_wr_i, halt_data_i,
      output status_wr_i, status_wr_data_i, half_frame_i,
      input  enabled_o, length_nzero_o, length_o
   );

   modport slave (
      input  load_wr_i, load_data_i, halt_wr_i, halt_data_i,
      input  status_wr_i, status_wr_data_i, half_frame_i,
      output enabled_o, length_nzero_o, length_o
   );

endinterface

// File: rtl/cpu_rp2a03_apu_length_counter_bank_slice.sv
// One length counter plus its halt flag. Define APU_LENGTH_LOAD_PRIORITY_EN to let a load win
// over a coincident decrement; by default the decrement wins and the load is discarded.
module cpu_rp2a03_apu_length_slice
   import cpu_rp2a03_apu_pkg::*;
#(
   parameter int unsigned LEN_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 en_i,
   input  logic                 load_wr_i,
   input  logic [LEN_IDX_W-1:0] load_idx_i,
   input  logic                 halt_wr_i,
   input  logic                 halt_data_i,
   input  logic                 half_frame_i,
   output logic [LEN_W-1:0]     len_o,
   output logic                 nzero_o
);

   logic [LEN_W-1:0] r_len;
   logic             r_halt;
   logic [LEN_W-1:0] w_len_d;
   logic [LEN_W-1:0] w_lut;
   logic             w_dec;

   assign w_lut = LEN_W'(length_lut(load_idx_i));
   // Registered halt: a halt write in the same cycle as a tick does not affect that tick.
   assign w_dec = half_frame_i & (r_len != '0) & ~r_halt;

   always_comb begin
      w_len_d = r_len;
      if (!en_i) begin
         w_len_d = '0;
`ifdef APU_LENGTH_LOAD_PRIORITY_EN
      end else if (load_wr_i) begin
         w_len_d = w_lut;
      end else if (w_dec) begin
         w_len_d = r_len - 1'b1;
`else
      end else if (w_dec) begin
         w_len_d = r_len - 1'b1;
      end else if (load_wr_i) begin
         w_len_d = w_lut;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_len  <= '0;
         r_halt <= 1'b0;
      end else begin
         r_len <= w_len_d;
         if (halt_wr_i) begin
            r_halt <= halt_data_i;
         end
      end
   end

   assign len_o   = r_len;
   assign nzero_o = (r_len != '0);

endmodule

// File: rtl/cpu_rp2a03_apu_length_counter_bank.sv
// Bank of APU length counters with the shared channel-enable register.
// Optional build macro: APU_LENGTH_LOAD_PRIORITY_EN (load beats decrement in the slices).
module cpu_rp2a03_apu_length_counter_bank
   import cpu_rp2a03_apu_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned LEN_W  = 8
) (
   input logic                                  clk_i,
   input logic                                  rst_n_i,
   cpu_rp2a03_apu_length_counter_bank_if.slave  bus_if
);

   logic [NUM_CH-1:0] r_enable;

   // Slices see the pre-write enable; a status write takes effect from the next cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_enable <= '0;
      end else if (bus_if.status_wr_i) begin
         r_enable <= bus_if.status_wr_data_i;
      end
   end

   assign bus_if.enabled_o = r_enable;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [LEN_W-1:0] w_len;
      logic             w_nzero;

      cpu_rp2a03_apu_length_slice #(
         .LEN_W (LEN_W)
      ) u_slice (
         .clk_i        (clk_i),
         .rst_n_i      (rst_n_i),
         .en_i         (r_enable[c]),
         .load_wr_i    (bus_if.load_wr_i[c]),
         .load_idx_i   (bus_if.load_data_i[LEN_IDX_W*c +: LEN_IDX_W]),
         .halt_wr_i    (bus_if.halt_wr_i[c]),
         .halt_data_i  (bus_if.halt_data_i[c]),
         .half_frame_i (bus_if.half_frame_i),
         .len_o        (w_len),
         .nzero_o      (w_nzero)
      );

      assign bus_if.length_o[LEN_W*c +: LEN_W] = w_len;
      assign bus_if.length_nzero_o[c]          = w_nzero;
   end

endmodule

// File: tb/tb_cpu_rp2a03_apu_length_counter_bank.sv
// Bench for the length counter bank: directed scenarios plus randomized traffic vs a model.
module tb_cpu_rp2a03_apu_length_counter_bank;

   localparam int NUM_CH = 4;
   localparam int LEN_W  = 8;

   logic clk;
   logic rst_n;

   cpu_rp2a03_apu_length_counter_bank_if #(.NUM_CH(NUM_CH), .LEN_W(LEN_W)) bus ();

   cpu_rp2a03_apu_length_counter_bank #(
      .NUM_CH (NUM_CH),
      .LEN_W  (LEN_W)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus_if  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Length table written out from its listed values.
   int lut [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                    12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

   int       m_len  [NUM_CH];
   bit       m_halt [NUM_CH];
   bit [3:0] m_en;
   int       vectors;
   int       errs;

   // Apply one cycle of stimulus, advance the model, check every output at the next negedge.
   task automatic cyc(input bit rst, input bit [3:0] lw, input bit [19:0] ld,
                      input bit [3:0] hw, input bit [3:0] hd,
                      input bit sw, input bit [3:0] swd, input bit hf);
      logic [31:0] exp_len;
      logic [3:0]  exp_nz;
      rst_n                = ~rst;
      bus.load_wr_i        = lw;
      bus.load_data_i      = ld;
      bus.halt_wr_i        = hw;
      bus.halt_data_i      = hd;
      bus.status_wr_i      = sw;
      bus.status_wr_data_i = swd;
      bus.half_frame_i     = hf;
      @(posedge clk);
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_len[c]  = 0;
            m_halt[c] = 0;
         end
         m_en = '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            bit dec;
            int tbl;
            dec = hf && (m_len[c] > 0) && !m_halt[c];
            tbl = lut[ld[5*c +: 5]];
            if (!m_en[c]) m_len[c] = 0;
`ifdef APU_LENGTH_LOAD_PRIORITY_EN
            else if (lw[c]) m_len[c] = tbl;
            else if (dec)   m_len[c] = m_len[c] - 1;
`else
            else if (dec)   m_len[c] = m_len[c] - 1;
            else if (lw[c]) m_len[c] = tbl;
`endif
            if (hw[c]) m_halt[c] = hd[c];
         end
         if (sw) m_en = swd;
      end
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
         exp_len[8*c +: 8] = 8'(m_len[c]);
         exp_nz[c]         = (m_len[c] != 0);
      end
      vectors++;
      if (bus.length_o !== exp_len || bus.length_nzero_o !== exp_nz || bus.enabled_o !== m_en)
      begin
         errs++;
         $display("FAIL cycle t=%0t: got len=%h nz=%b en=%b, want len=%h nz=%b en=%b",
                  $time, bus.length_o, bus.length_nzero_o, bus.enabled_o,
                  exp_len, exp_nz, m_en);
      end
   endtask

   task automatic idle(input bit hf);
      cyc(1'b0, 4'h0, 20'h0, 4'h0, 4'h0, 1'b0, 4'h0, hf);
   endtask

   task automatic lit(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic int dlen(input int c);
      return int'(bus.length_o[8*c +: 8]);
   endfunction

   initial begin
      vectors = 0;
      errs    = 0;
      cyc(1'b1, 4'h0, 20'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      cyc(1'b1, 4'hF, 20'hFFFFF, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
      lit("reset_len", int'(bus.length_o), 0);
      lit("reset_en", int'(bus.enabled_o), 0);
      lit("reset_nz", int'(bus.length_nzero_o), 0);

      // Enable ch0, load 30.
      cyc(1'b0, 4'h0, 20'h0, 4'h0, 4'h0, 1'b1, 4'b0001, 1'b0);
      cyc(1'b0, 4'b0001, 20'h0001F, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      lit("ch0_load30", dlen(0), 30);
      lit("ch0_nz", int'(bus.length_nzero_o), 1);
      for (int i = 0; i < 29; i++) idle(1'b1);
      lit("ch0_after29", dlen(0), 1);
      idle(1'b1);
      lit("ch0_after30", dlen(0), 0);
      lit("ch0_nz_drop", int'(bus.length_nzero_o), 0);
      idle(1'b1);
      lit("ch0_nowrap", dlen(0), 0);

      // Ch1 halt.
      cyc(1'b0, 4'h0, 20'h0, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0);
      cyc(1'b0, 4'b0010, 20'h18 << 5, 4'b0010, 4'b0010, 1'b0, 4'h0, 1'b0);
      lit("ch1_load192", dlen(1), 192);
      for (int i = 0; i < 10; i++) idle(1'b1);
      lit("ch1_halted", dlen(1), 192);
      cyc(1'b0, 4'h0, 20'h0, 4'b0010, 4'b0000, 1'b0, 4'h0, 1'b1);
      lit("ch1_old_halt", dlen(1), 192);
      idle(1'b1);
      lit("ch1_unhalted", dlen(1), 191);

      // Ch2 disable clears, load while disabled dropped.
      cyc(1'b0, 4'b0100, 20'h14 << 10, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      lit("ch2_load48", dlen(2), 48);
      cyc(1'b0, 4'h0, 20'h0, 4'h0, 4'h0, 1'b1, 4'b1011, 1'b0);
      lit("ch2_write_cycle", dlen(2), 48);
      idle(1'b0);
      lit("ch2_cleared", dlen(2), 0);
      cyc(1'b0, 4'b0100, 20'h14 << 10, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      lit("ch2_load_dropped", dlen(2), 0);

      // Ch3 load coinciding with a decrement.
      cyc(1'b0, 4'h0, 20'h0, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0);
      cyc(1'b0, 4'b1000, 20'h00000, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      lit("ch3_load10", dlen(3), 10);
      cyc(1'b0, 4'b1000, 20'h01 << 15, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1);
`ifdef APU_LENGTH_LOAD_PRIORITY_EN
      lit("ch3_load_vs_tick", dlen(3), 254);
`else
      lit("ch3_load_vs_tick", dlen(3), 9);
`endif

      // Ch0 at zero: load in a tick cycle always lands.
      cyc(1'b0, 4'b0001, 20'h00010, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1);
      lit("ch0_load_from_zero", dlen(0), 12);
      cyc(1'b0, 4'hF, {5'h00, 5'h14, 5'h18, 5'h1F}, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      lit("all_ch0", dlen(0), 30);
      lit("all_ch1", dlen(1), 192);
      lit("all_ch2", dlen(2), 48);
      lit("all_ch3", dlen(3), 10);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit [3:0] lw, hw, hd, swd;
         bit       sw, hf, rst;
         for (int c = 0; c < NUM_CH; c++) begin
            lw[c] = ($urandom_range(0, 7) == 0);
            hw[c] = ($urandom_range(0, 15) == 0);
         end
         hd  = 4'($urandom());
         sw  = ($urandom_range(0, 15) == 0);
         swd = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
         hf  = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 299) == 0);
         cyc(rst, lw, 20'($urandom()), hw, hd, sw, swd, hf);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
